// File: rtl/mem_master_bridge.sv
// PicoRV32 native memory port to single-port synchronous MEMORY bridge.
// Partial-word stores become read-modify-write; out-of-range and timed-out accesses report err.
module mem_master_bridge #(
    parameter int SIZE    = 14,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [31:0]      mem_addr,
    input  logic [WIDTH-1:0] mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [WIDTH-1:0] mem_rdata,
    output logic             err,
    output logic             m_en,
    output logic             m_write,
    output logic [SIZE-1:0]  m_addr,
    output logic [WIDTH-1:0] m_din,
    input  logic [WIDTH-1:0] m_dout,
    input  logic             m_rdy
);

    typedef enum logic [2:0] {
        IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, RESP
    } state_t;

    state_t           r_state, w_next_state;
    logic [SIZE-1:0]  r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [3:0]       r_wstrb;
    logic             r_oor;
    logic [3:0]       r_cnt, w_cnt_next;
    logic             w_accept, w_oor, w_in_wait, w_timeout;
    logic [WIDTH-1:0] w_merged;

    logic             r_mem_ready, w_mem_ready;
    logic [WIDTH-1:0] r_mem_rdata, w_mem_rdata;
    logic             r_err, w_err;
    logic             r_m_en, w_m_en;
    logic             r_m_write, w_m_write;
    logic [SIZE-1:0]  r_m_addr, w_m_addr;
    logic [WIDTH-1:0] r_m_din, w_m_din;

    assign mem_ready = r_mem_ready;
    assign mem_rdata = r_mem_rdata;
    assign err       = r_err;
    assign m_en      = r_m_en;
    assign m_write   = r_m_write;
    assign m_addr    = r_m_addr;
    assign m_din     = r_m_din;

    assign w_oor      = (mem_addr >> (SIZE + 2)) != 32'd0;
    assign w_accept   = (r_state == IDLE) && mem_valid && !r_mem_ready;
    assign w_in_wait  = (r_state == RD_WAIT) || (r_state == RMW_WAIT);
    assign w_cnt_next = r_cnt + 4'd1;
    assign w_timeout  = (w_cnt_next == 4'(TIMEOUT));

    always_comb begin
        w_merged = m_dout;
        for (int i = 0; i < 4; i++) begin
            if (r_wstrb[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_mem_ready  = 1'b0;
        w_mem_rdata  = '0;
        w_err        = 1'b0;
        w_m_en       = 1'b0;
        w_m_write    = 1'b0;
        w_m_addr     = r_m_addr;
        w_m_din      = r_m_din;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_oor)                   w_next_state = RESP;
                    else if (mem_wstrb == 4'h0)  w_next_state = RD;
                    else if (mem_wstrb == 4'hF)  w_next_state = WR;
                    else                         w_next_state = RMW_RD;
                end
            end
            RD, RMW_RD: begin
                w_m_en       = 1'b1;
                w_m_addr     = r_addr;
                w_next_state = (r_state == RD) ? RD_WAIT : RMW_WAIT;
            end
            RD_WAIT, RMW_WAIT: begin
                if (m_rdy && r_state == RD_WAIT) begin
                    w_mem_ready  = 1'b1;
                    w_mem_rdata  = m_dout;
                    w_next_state = RESP;
                end else if (m_rdy) begin
                    w_m_en       = 1'b1;
                    w_m_write    = 1'b1;
                    w_m_addr     = r_addr;
                    w_m_din      = w_merged;
                    w_next_state = RMW_WR;
                end else if (w_timeout) begin
                    // Abort without writing: the merge source never arrived.
                    w_mem_ready  = 1'b1;
                    w_err        = 1'b1;
                    w_mem_rdata  = '1;
                    w_next_state = RESP;
                end
            end
            WR: begin
                w_m_en       = 1'b1;
                w_m_write    = 1'b1;
                w_m_addr     = r_addr;
                w_m_din      = r_wdata;
                w_next_state = RESP;
            end
            RMW_WR: begin
                w_mem_ready  = 1'b1;
                w_next_state = RESP;
            end
            RESP: begin
                // Writes and range errors arrive here before the response has been raised.
                if (!r_mem_ready) begin
                    w_mem_ready = 1'b1;
                    w_err       = r_oor;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
            r_err       <= 1'b0;
            r_m_en      <= 1'b0;
            r_m_write   <= 1'b0;
            r_m_addr    <= '0;
            r_m_din     <= '0;
        end else begin
            r_state     <= w_next_state;
            r_mem_ready <= w_mem_ready;
            r_mem_rdata <= w_mem_rdata;
            r_err       <= w_err;
            r_m_en      <= w_m_en;
            r_m_write   <= w_m_write;
            r_m_addr    <= w_m_addr;
            r_m_din     <= w_m_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_oor   <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= mem_addr[SIZE+1:2];
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_oor   <= w_oor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         r_cnt <= '0;
        else if (w_in_wait && w_next_state == r_state)   r_cnt <= w_cnt_next;
        else                                             r_cnt <= '0;
    end

endmodule

// File: tb/tb_mem_master_bridge.sv
// Directed bench for mem_master_bridge with a behavioural synchronous MEMORY model.
// Covers read/write/RMW latency, range errors, timeout, mid-operation reset and back-to-back traffic.
module tb_mem_master_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err;
    logic        m_en;
    logic        m_write;
    logic [13:0] m_addr;
    logic [31:0] m_din;
    logic [31:0] m_dout;
    logic        m_rdy;

    logic        stub = 1'b0;
    logic        extra_rdy = 1'b0;
    logic        rdy_q = 1'b0;
    logic [31:0] mem [0:16383];

    int n_checks = 0;
    int n_err    = 0;
    int en_viol  = 0;
    int wr_viol  = 0;
    logic prev_en = 1'b0;

    mem_master_bridge #(.SIZE(14), .WIDTH(32), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .err       (err),
        .m_en      (m_en),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_din     (m_din),
        .m_dout    (m_dout),
        .m_rdy     (m_rdy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: responds one cycle after en; stub suppresses ready.
    always @(posedge clk) begin
        if (m_en && m_write)  mem[m_addr] <= m_din;
        if (m_en && !m_write) m_dout <= mem[m_addr];
        rdy_q <= m_en && !stub;
    end
    assign m_rdy = rdy_q | extra_rdy;

    always @(negedge clk) begin
        prev_en <= m_en;
        if (m_en && prev_en) en_viol <= en_viol + 1;
        if (m_write && !m_en) wr_viol <= wr_viol + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rdata, output logic e, output int lat,
                          output int n_en, output int n_wr, output logic [13:0] maddr);
        rdata = '0; e = 1'b0; lat = -1; n_en = 0; n_wr = 0; maddr = '0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        @(posedge clk);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (m_en) begin n_en++; maddr = m_addr; end
            if (m_write) n_wr++;
            if (mem_ready) begin
                lat = c; rdata = mem_rdata; e = err;
                break;
            end
        end
        mem_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_en;
        int          n_wr;
        logic [13:0] maddr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } b2b_t;

    vec_t vecs [12];
    b2b_t seq  [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat, n_en, n_wr, n_rdy, idx, wr_seen;
        logic [13:0] ma;

        vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 2, 1, 1, 14'h4};
        vecs[1]  = '{32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 3, 1, 0, 14'h4};
        vecs[2]  = '{32'h0000_0010, 32'h1122_3344, 4'hF, 32'h0,         1'b0, 2, 1, 1, 14'h4};
        vecs[3]  = '{32'h0000_0010, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0, 4, 2, 1, 14'h4};
        vecs[4]  = '{32'h0000_0010, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0, 3, 1, 0, 14'h4};
        vecs[5]  = '{32'h0001_0000, 32'h0,         4'h0, 32'h0,         1'b1, 1, 0, 0, 14'h0};
        vecs[6]  = '{32'h0000_FFFC, 32'h0102_0304, 4'hF, 32'h0,         1'b0, 2, 1, 1, 14'h3FFF};
        vecs[7]  = '{32'h0000_FFFF, 32'h0,         4'h0, 32'h0102_0304, 1'b0, 3, 1, 0, 14'h3FFF};
        vecs[8]  = '{32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1, 1, 0, 0, 14'h0};
        vecs[9]  = '{32'h0000_0012, 32'hCAFE_0000, 4'hC, 32'h0,         1'b0, 4, 2, 1, 14'h4};
        vecs[10] = '{32'h0000_0010, 32'h0,         4'h0, 32'hCAFE_33DD, 1'b0, 3, 1, 0, 14'h4};
        vecs[11] = '{32'h0001_0010, 32'h0,         4'h0, 32'h0,         1'b1, 1, 0, 0, 14'h0};

        seq[0] = '{32'h10, 32'h0,         4'h0, 32'hCAFE_33DD};
        seq[1] = '{32'h40, 32'h0000_1111, 4'hF, 32'h0};
        seq[2] = '{32'h40, 32'h0,         4'h0, 32'h0000_1111};
        seq[3] = '{32'h10, 32'h2222_0000, 4'hF, 32'h0};
        seq[4] = '{32'h10, 32'h0,         4'h0, 32'h2222_0000};
        seq[5] = '{32'h40, 32'h3333_3333, 4'hF, 32'h0};

        // Reset state
        #1;
        check("reset_ctrl", {28'h0, mem_ready, err, m_en, m_write}, 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ctrl", {28'h0, mem_ready, err, m_en, m_write}, 32'h0);

        // Table-driven transactions
        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, e, lat, n_en, n_wr, ma);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_err", i), {31'h0, e}, {31'h0, vecs[i].err});
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_m_en_count", i), n_en, vecs[i].n_en);
            check($sformatf("v%0d_m_write_count", i), n_wr, vecs[i].n_wr);
            if (vecs[i].n_en > 0) check($sformatf("v%0d_m_addr", i), {18'h0, ma}, {18'h0, vecs[i].maddr});
        end
        check("mem_word4", mem[4], 32'hCAFE_33DD);
        check("mem_top_word", mem[16383], 32'h0102_0304);

        // Timeout on partial write and on read with the memory stubbed
        stub = 1'b1;
        do_txn(32'h10, 32'h0000_00EE, 4'h3, rd, e, lat, n_en, n_wr, ma);
        check("to_rmw_rdata", rd, 32'hFFFF_FFFF);
        check("to_rmw_err", {31'h0, e}, 32'h1);
        check("to_rmw_latency", lat, 16);
        check("to_rmw_m_en_count", n_en, 1);
        check("to_rmw_m_write_count", n_wr, 0);
        do_txn(32'h10, 32'h0, 4'h0, rd, e, lat, n_en, n_wr, ma);
        check("to_rd_rdata", rd, 32'hFFFF_FFFF);
        check("to_rd_err", {31'h0, e}, 32'h1);
        check("to_rd_latency", lat, 16);
        stub = 1'b0;
        check("to_mem_word4", mem[4], 32'hCAFE_33DD);

        // Reset in cycle 2 of a partial write
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h10; mem_wdata = 32'h0000_00FF; mem_wstrb = 4'h1;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        check("rst_seq_read_en", {31'h0, m_en}, 32'h1);
        check("rst_seq_read_addr", {18'h0, m_addr}, 32'h4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {28'h0, mem_ready, err, m_en, m_write}, 32'h0);
        check("rst_mid_m_addr", {18'h0, m_addr}, 32'h0);
        check("rst_mid_m_din", m_din, 32'h0);
        check("rst_mid_rdata", mem_rdata, 32'h0);
        wr_seen = 0;
        repeat (2) begin @(negedge clk); if (m_write) wr_seen++; end
        rst = 1'b0;
        repeat (4) begin @(negedge clk); if (m_write) wr_seen++; end
        check("rst_no_write", wr_seen, 0);
        check("rst_mem_word4", mem[4], 32'hCAFE_33DD);

        // Stray m_rdy while idle has no effect
        @(negedge clk); extra_rdy = 1'b1;
        @(negedge clk); extra_rdy = 1'b0;
        check("stale_rdy_no_ready_a", {31'h0, mem_ready}, 32'h0);
        @(negedge clk);
        check("stale_rdy_no_ready_b", {31'h0, mem_ready}, 32'h0);
        do_txn(32'h10, 32'h0, 4'h0, rd, e, lat, n_en, n_wr, ma);
        check("after_rst_read", rd, 32'hCAFE_33DD);
        check("after_rst_latency", lat, 3);

        // Back-to-back with mem_valid held high
        n_rdy = 0; n_en = 0; idx = 0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = seq[0].addr; mem_wdata = seq[0].wdata; mem_wstrb = seq[0].wstrb;
        for (int c = 0; c < 200 && idx < 6; c++) begin
            @(negedge clk);
            if (m_en) n_en++;
            if (mem_ready) begin
                n_rdy++;
                if (seq[idx].wstrb == 4'h0) check($sformatf("b2b_%0d_rdata", idx), mem_rdata, seq[idx].exp);
                idx++;
                if (idx < 6) begin
                    mem_addr = seq[idx].addr; mem_wdata = seq[idx].wdata; mem_wstrb = seq[idx].wstrb;
                end else begin
                    mem_valid = 1'b0;
                end
            end
        end
        mem_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (m_en) n_en++;
            if (mem_ready) n_rdy++;
        end
        check("b2b_ready_count", n_rdy, 6);
        check("b2b_m_en_count", n_en, 6);
        check("b2b_mem_word16", mem[16], 32'h3333_3333);
        check("m_en_back_to_back", en_viol, 0);
        check("m_write_without_en", wr_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
